muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit for the EX stage; sits beside the single-cycle ALU.
- Sequences a shared N-bit add/subtract step over N cycles for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Holds the pipeline through a busy/done handshake with the hazard unit.

Parameters:
- N, 32, operand/result width (XLEN).
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort of the in-flight op
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- A  input  N  rs1 operand, sampled with start
- B  input  N  rs2 operand, sampled with start
- busy  output  1  high in CALC and FIXUP; pipeline stall request
- done  output  1  one-cycle pulse; result valid
- result  output  N  registered result, held until the next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; counter, accumulator and operand registers all 0.
- States and transitions:
  - IDLE: on start, latch op, A and B, then go to CALC or take a special-case exit.
  - CALC: one step per cycle; counter runs 0..N-1; at N-1 go to FIXUP.
  - FIXUP: apply sign correction and select the high/low half; go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency, normal op: start high in cycle 0; CALC occupies cycles 1..N; FIXUP is cycle N+1; done=1 in cycle N+2 (cycle 34 at N=32). busy=1 in cycles 1..N+1. Next start is accepted no earlier than cycle N+3.
- Special cases (IDLE goes straight to DONE; done in cycle 1; busy never asserted):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give A.
  - Signed overflow: DIV with A=0x80000000 and B=0xFFFFFFFF gives 0x80000000; REM gives 0.
- Multiply:
  - Signed operands are converted to magnitudes first: MULH converts both, MULHSU converts A only.
  - Unsigned shift-add into a 2N-bit product.
  - FIXUP negates the product when the operand signs differ.
  - MUL returns product[N-1:0]; the MULH variants return product[2N-1:N].
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - Truncation is toward zero.
- Handshake rules:
  - start while busy or in DONE is ignored; no queueing.
  - start with flush in the same IDLE cycle: flush wins, no op is launched.
- flush in CALC or FIXUP: return to IDLE next cycle, no done pulse, result unchanged.
- Async reset mid-operation: immediate return to IDLE with all outputs 0.
- A and B changing after start has no effect, because the operands are latched.
- result is updated only on entry to DONE.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (funct3 constants).
  - state enum IDLE/CALC/FIXUP/DONE.
  - XLEN default.
  - DIV_BY_ZERO_Q constant (all ones).
- Sub-module muldiv_step: combinational single-iteration datapath.
  - Multiply mode: conditional add of the multiplicand plus shift.
  - Divide mode: trial subtract, restore, shift in the quotient bit.
  - Instantiated once; the sequencer owns all registers.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> done in cycle 34, result=0xFFFFFFEB; busy high in cycles 1..33.
- MULHU A=B=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000; MULHSU A=-1, B=2 -> result=0xFFFFFFFF.
- DIV A=-7, B=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFF (-1); DIVU 100/7 -> result=14; REMU 100/7 -> result=2.
- Boundary values, each giving done in cycle 1 with busy never high:
  - DIVU A=5, B=0 -> result=0xFFFFFFFF.
  - REM A=5, B=0 -> result=5.
  - DIV 0x80000000/0xFFFFFFFF -> result=0x80000000.
  - REM with the same operands -> result=0.
- Handshake abuse:
  - start pulsed again in cycle 10 -> ignored, only one done at cycle 34.
  - flush in cycle 20 -> IDLE in cycle 21, no done, result keeps its previous value.
- rst asserted asynchronously mid-CALC (cycle 15) -> busy, done and result drop to 0 immediately; a new start after reset release completes normally in 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Funct3 encodings, sequencer states and divide-by-zero constant.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared add/subtract datapath.
// Multiply: shift-add on {acc,q}; divide: restoring step on {acc,q}.
module muldiv_step #(
    parameter int N = 32
) (
    input  logic         i_div,
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_m,
    output logic [N-1:0] o_acc,
    output logic [N-1:0] o_q
);

    logic [N:0]   w_sum;
    logic [N:0]   w_shl;
    logic [N-1:0] w_sub;
    logic         w_ge;

    // multiply: add multiplicand when the low multiplier bit is set
    assign w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);

    // divide: shift remainder left, pulling in the next dividend bit
    assign w_shl = {i_acc, i_q[N-1]};
    assign w_ge  = (w_shl >= {1'b0, i_m});
    // the difference is below the divisor whenever it is kept, so N bits suffice
    assign w_sub = w_shl[N-1:0] - i_m;

    // select the step result for the active mode
    always_comb begin
        o_acc = '0;
        o_q   = '0;
        if (i_div) begin
            o_acc = w_ge ? w_sub : w_shl[N-1:0];
            o_q   = {i_q[N-2:0], w_ge};
        end else begin
            o_acc = w_sum[N:1];
            o_q   = {w_sum[0], i_q[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Runs N shared steps, then a sign fixup, then a one-cycle done pulse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int N  = XLEN,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         r_state;
    state_t         w_state_nx;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_op;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_m;
    logic           r_neg;
    logic [N-1:0]   r_result;

    logic           w_launch;
    logic           w_sgn_a;
    logic           w_sgn_b;
    logic           w_neg_a;
    logic           w_neg_b;
    logic           w_neg;
    logic           w_div0;
    logic           w_ovf;
    logic           w_special;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic [N-1:0]   w_spec_res;
    logic [N-1:0]   w_step_acc;
    logic [N-1:0]   w_step_q;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_fix_res;

    // MUL low half is sign-agnostic, so only the MULH family and
    // signed divides work on magnitudes
    assign w_sgn_a = (op == OP_MULH) || (op == OP_MULHSU)
                  || (op == OP_DIV)  || (op == OP_REM);
    assign w_sgn_b = (op == OP_MULH) || (op == OP_DIV)
                  || (op == OP_REM);
    assign w_neg_a = w_sgn_a && A[N-1];
    assign w_neg_b = w_sgn_b && B[N-1];
    assign w_mag_a = w_neg_a ? -A : A;
    assign w_mag_b = w_neg_b ? -B : B;

    // remainder follows the dividend; everything else follows sign xor
    assign w_neg = (op == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_div0    = op[2] && (B == '0);
    assign w_ovf     = ((op == OP_DIV) || (op == OP_REM))
                    && (A == MIN_NEG) && (B == '1);
    assign w_special = w_div0 || w_ovf;

    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign w_spec_res = w_div0 ? (op[1] ? A : N'(DIV_BY_ZERO_Q))
                               : (op[1] ? '0 : MIN_NEG);

    assign w_launch = (r_state == ST_IDLE) && start && !flush;

    muldiv_step #(
        .N (N)
    ) u_step (
        .i_div (r_op[2]),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_m   (r_m),
        .o_acc (w_step_acc),
        .o_q   (w_step_q)
    );

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg ? -r_q : r_q;
    assign w_rem_fix  = r_neg ? -r_acc : r_acc;

    assign w_fix_res = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                     : (r_op == OP_MUL) ? w_prod_fix[N-1:0]
                     : w_prod_fix[2*N-1:N];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nx = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == CW'(N - 1)) begin
                    w_state_nx = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                busy       = 1'b1;
                w_state_nx = flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // operand latch, iteration registers and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_launch) begin
                r_op  <= op;
                r_cnt <= '0;
                r_acc <= '0;
                r_q   <= w_mag_a;
                r_m   <= w_mag_b;
                r_neg <= w_neg;
            end else if (r_state == ST_CALC) begin
                r_acc <= w_step_acc;
                r_q   <= w_step_q;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_launch && w_special) begin
                r_result <= w_spec_res;
            end else if ((r_state == ST_FIXUP) && !flush) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a per-cycle reference model.
// The model predicts busy/done/result from arithmetic and a cycle countdown.
module tb_muldiv_sequencer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    muldiv_sequencer #(.N(N), .CW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p = 0;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = longint'(64'(ua * ub) >> 32);
            3'd4: begin
                if (b == 0) p = -1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = sa;
                else p = sa / sb;
            end
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: begin
                if (b == 0) p = sa;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic bit ref_special(input logic [2:0] o,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (!o[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (o == 3'd4 || o == 3'd6)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // model: cycles left until done, pending result, done pulse
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_pend = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        m_res  <= m_pend;
                    end
                end
            end else if (!m_done && start && !flush) begin
                m_pend <= ref_res(op, A, B);
                if (ref_special(op, A, B)) begin
                    m_done <= 1'b1;
                    m_res  <= ref_res(op, A, B);
                end else begin
                    m_left <= N + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("cyc_done", {31'd0, done}, {31'd0, m_done});
        check("cyc_result", result, m_res);
    end

    task automatic wait_until(input int c0, input int k);
        while (cyc - c0 < k) @(negedge clk);
    endtask

    task automatic do_op(input string nm, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int c0;
        int got_lat;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        got_lat = -1;
        for (int i = 0; i < 60 && got_lat < 0; i++) begin
            if (done) got_lat = cyc - c0;
            else @(negedge clk);
        end
        check({nm, "_lat"}, got_lat, lat);
        check({nm, "_res"}, result, exp);
        @(negedge clk);
    endtask

    int c0;
    int nd;
    int ld;
    int nb;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        check("pin_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulhu", ref_res(3'd3, '1, '1), 32'hFFFF_FFFE);
        check("pin_mulhsu", ref_res(3'd2, '1, 32'd2), 32'hFFFF_FFFF);
        check("pin_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("pin_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
        do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        do_op("div_nb", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        do_op("rem_nb", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        do_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_z", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // second start while busy is ignored
        @(negedge clk);
        op = 3'd3; A = '1; B = '1; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_until(c0, 10);
        op = 3'd5; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; ld = -1;
        while (cyc - c0 < 40) begin
            if (done) begin nd++; ld = cyc - c0; end
            @(negedge clk);
        end
        check("abuse_ndone", nd, 32'd1);
        check("abuse_lat", ld, 32'd34);
        check("abuse_res", result, 32'hFFFF_FFFE);

        // flush mid-CALC drops the op and keeps the old result
        op = 3'd0; A = 32'd7; B = 32'hFFFF_FFFD; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_until(c0, 20);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        nd = 0;
        while (cyc - c0 < 40) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("flush_ndone", nd, 32'd0);
        check("flush_res", result, 32'hFFFF_FFFE);

        // start together with flush in IDLE launches nothing
        op = 3'd5; A = 32'd5; B = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        nd = 0; nb = 0;
        repeat (5) begin
            if (done) nd++;
            if (busy) nb++;
            @(negedge clk);
        end
        check("sf_ndone", nd, 32'd0);
        check("sf_nbusy", nb, 32'd0);
        check("sf_res", result, 32'hFFFF_FFFE);

        // async reset mid-CALC
        op = 3'd3; A = '1; B = '1; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_until(c0, 15);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_res", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
